// File: rtl/ram_dma_ci_pkg.sv
// ============================================================================
//  Module      : ram_dma_ci_pkg
//  Description : Shared definitions for the scratch-RAM / DMA custom
//                instruction block: CI register selects, DMA control codes
//                and the DMA state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_dma_ci_pkg;

    // CI register map, selected by valueA[12:10]
    localparam logic [2:0] SEL_RAM      = 3'd0;
    localparam logic [2:0] SEL_BUS_ADDR = 3'd1;
    localparam logic [2:0] SEL_RAM_ADDR = 3'd2;
    localparam logic [2:0] SEL_BLOCK    = 3'd3;
    localparam logic [2:0] SEL_BURST    = 3'd4;
    localparam logic [2:0] SEL_CTRL     = 3'd5;

    // Control register codes; any other value written is ignored
    localparam logic [31:0] CTRL_READ  = 32'd1;  // bus -> RAM
    localparam logic [31:0] CTRL_WRITE = 32'd2;  // RAM -> bus

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_BEGIN = 3'd2,
        ST_RD    = 3'd3,
        ST_WR    = 3'd4,
        ST_END   = 3'd5,
        ST_NEXT  = 3'd6
    } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/ram_dma_ci_ram.sv
// ============================================================================
//  Module      : ram_dp_512x32
//  Description : 512x32 dual-port RAM, asynchronous read, synchronous write.
//                On a same-address same-cycle write the DMA port wins.
//  Ports       : clock         - write clock
//                cpu_we_i/cpu_addr_i/cpu_wdata_i/cpu_rdata_o - CPU port
//                dma_we_i/dma_addr_i/dma_wdata_i/dma_rdata_o - DMA port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dp_512x32 (
    input  logic        clock,
    input  logic        cpu_we_i,
    input  logic [8:0]  cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    input  logic        dma_we_i,
    input  logic [8:0]  dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic [31:0] dma_rdata_o
);

    logic [31:0] mem_q [512];

    // DMA write is issued last so it overrides a colliding CPU write
    always_ff @(posedge clock) begin
        if (cpu_we_i) mem_q[cpu_addr_i] <= cpu_wdata_i;
        if (dma_we_i) mem_q[dma_addr_i] <= dma_wdata_i;
    end

    assign cpu_rdata_o = mem_q[cpu_addr_i];
    assign dma_rdata_o = mem_q[dma_addr_i];

endmodule

`default_nettype wire

// File: rtl/ram_dma_ci.sv
// ============================================================================
//  Module      : ram_dma_ci
//  Description : Custom-instruction block with a 512x32 scratch RAM and a
//                burst DMA engine mastering the system bus.
//  Ports       : clock, reset            - clock, sync active-high reset
//                start, ciN, valueA/B    - CI request (A: [12:10] select,
//                                          [9] write, [8:0] RAM address)
//                done, result            - CI response (combinational)
//                granted, address_data_in, end_transaction_in,
//                data_valid_in, busy_in, error_in - bus slave/arbiter inputs
//                request, address_data_out, byte_enables_out,
//                burst_size_out, read_n_write_out, begin_transaction_out,
//                end_transaction_out, data_valid_out - bus master outputs
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_dma_ci
    import ram_dma_ci_pkg::*;
#(
    parameter logic [7:0] customId = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  ciN,
    output logic        done,
    output logic [31:0] result,
    input  logic        granted,
    input  logic [31:0] address_data_in,
    input  logic        end_transaction_in,
    input  logic        data_valid_in,
    input  logic        busy_in,
    input  logic        error_in,
    output logic        request,
    output logic [31:0] address_data_out,
    output logic [3:0]  byte_enables_out,
    output logic [7:0]  burst_size_out,
    output logic        read_n_write_out,
    output logic        begin_transaction_out,
    output logic        end_transaction_out,
    output logic        data_valid_out
);

    logic        sel, ci_wr, ctrl_accept, busy, dma_we;
    logic [2:0]  reg_sel;
    logic [8:0]  ci_addr, burst_len, first_len;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        unused_valuea;

    // Configuration registers (CPU-visible, never touched by the DMA)
    logic [31:0] bus_addr_q;
    logic [8:0]  ram_addr_q;
    logic [9:0]  block_q;
    logic [7:0]  burst_q;

    // Transfer working copies
    dma_state_e  state_q, state_d;
    logic [31:0] cur_bus_q, cur_bus_d;
    logic [8:0]  cur_ram_q, cur_ram_d;
    logic [9:0]  remain_q, remain_d;
    logic [8:0]  left_q, left_d;      // beats still owed in this burst
    logic [7:0]  cur_burst_q, cur_burst_d;
    logic        rd_q, rd_d, error_q, error_d;

    assign sel           = start && (ciN == customId);
    assign reg_sel       = valueA[12:10];
    assign ci_wr         = valueA[9];
    assign ci_addr       = valueA[8:0];
    assign unused_valuea = ^valueA[31:13];
    assign busy          = (state_q != ST_IDLE);
    assign ctrl_accept   = sel && ci_wr && (reg_sel == SEL_CTRL) && !busy &&
                           ((valueB == CTRL_READ) || (valueB == CTRL_WRITE));
    assign done          = sel;

    ram_dp_512x32 u_ram (
        .clock       (clock),
        .cpu_we_i    (sel && ci_wr && (reg_sel == SEL_RAM)),
        .cpu_addr_i  (ci_addr),
        .cpu_wdata_i (valueB),
        .cpu_rdata_o (cpu_rdata),
        .dma_we_i    (dma_we),
        .dma_addr_i  (cur_ram_q),
        .dma_wdata_i (address_data_in),
        .dma_rdata_o (dma_rdata)
    );

    always_comb begin
        result = 32'd0;
        if (sel && !ci_wr) begin
            case (reg_sel)
                SEL_RAM:      result = cpu_rdata;
                SEL_BUS_ADDR: result = bus_addr_q;
                SEL_RAM_ADDR: result = {23'd0, ram_addr_q};
                SEL_BLOCK:    result = {22'd0, block_q};
                SEL_BURST:    result = {24'd0, burst_q};
                SEL_CTRL:     result = {30'd0, error_q, busy};
                default:      result = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus_addr_q <= 32'd0;
            ram_addr_q <= 9'd0;
            block_q    <= 10'd0;
            burst_q    <= 8'd0;
        end else if (sel && ci_wr) begin
            case (reg_sel)
                SEL_BUS_ADDR: bus_addr_q <= valueB;
                SEL_RAM_ADDR: ram_addr_q <= valueB[8:0];
                SEL_BLOCK:    block_q    <= valueB[9:0];
                SEL_BURST:    burst_q    <= valueB[7:0];
                default:      ;
            endcase
        end
    end

    // Burst length is the programmed size, clipped to what is left
    assign burst_len = {1'b0, cur_burst_q} + 9'd1;
    assign first_len = (remain_q < {1'b0, burst_len}) ? remain_q[8:0] : burst_len;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_bus_q   <= 32'd0;
            cur_ram_q   <= 9'd0;
            remain_q    <= 10'd0;
            left_q      <= 9'd0;
            cur_burst_q <= 8'd0;
            rd_q        <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_bus_q   <= cur_bus_d;
            cur_ram_q   <= cur_ram_d;
            remain_q    <= remain_d;
            left_q      <= left_d;
            cur_burst_q <= cur_burst_d;
            rd_q        <= rd_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        cur_bus_d             = cur_bus_q;
        cur_ram_d             = cur_ram_q;
        remain_d              = remain_q;
        left_d                = left_q;
        cur_burst_d           = cur_burst_q;
        rd_d                  = rd_q;
        error_d               = error_q;
        dma_we                = 1'b0;
        request               = 1'b0;
        address_data_out      = 32'd0;
        byte_enables_out      = 4'h0;
        burst_size_out        = 8'd0;
        read_n_write_out      = 1'b0;
        begin_transaction_out = 1'b0;
        end_transaction_out   = 1'b0;
        data_valid_out        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_accept) begin
                    error_d     = 1'b0;
                    cur_bus_d   = bus_addr_q;
                    cur_ram_d   = ram_addr_q;
                    remain_d    = block_q;
                    cur_burst_d = burst_q;
                    rd_d        = (valueB == CTRL_READ);
                    if (block_q != 10'd0) state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                request = 1'b1;
                if (granted) state_d = ST_BEGIN;
            end
            ST_BEGIN: begin
                request               = 1'b1;
                begin_transaction_out = 1'b1;
                address_data_out      = cur_bus_q;
                byte_enables_out      = 4'hF;
                // first_len is 1..256, so the 8-bit wrap of 256-1 is exact
                burst_size_out        = first_len[7:0] - 8'd1;
                read_n_write_out      = rd_q;
                left_d                = first_len;
                state_d               = rd_q ? ST_RD : ST_WR;
            end
            ST_RD: begin
                request = 1'b1;
                // Beats beyond the announced burst length are discarded
                if (data_valid_in && (left_q != 9'd0)) begin
                    dma_we    = 1'b1;
                    cur_ram_d = cur_ram_q + 9'd1;
                    cur_bus_d = cur_bus_q + 32'd4;
                    remain_d  = remain_q - 10'd1;
                    left_d    = left_q - 9'd1;
                end
                if (end_transaction_in) state_d = ST_NEXT;
            end
            ST_WR: begin
                request          = 1'b1;
                data_valid_out   = 1'b1;
                address_data_out = dma_rdata;
                if (!busy_in) begin
                    cur_ram_d = cur_ram_q + 9'd1;
                    cur_bus_d = cur_bus_q + 32'd4;
                    remain_d  = remain_q - 10'd1;
                    left_d    = left_q - 9'd1;
                    if (left_q == 9'd1) state_d = ST_END;
                end
            end
            ST_END: begin
                request             = 1'b1;
                end_transaction_out = 1'b1;
                state_d             = ST_NEXT;
            end
            ST_NEXT: begin
                state_d = (remain_q == 10'd0) ? ST_IDLE : ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase

        // A bus error abandons the transfer; outputs fall with the IDLE state
        if (busy && error_in) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
            dma_we  = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_dma_ci.sv
// ============================================================================
//  Module      : tb_ram_dma_ci
//  Description : Self-checking bench for ram_dma_ci with a randomized bus
//                slave and a word-level reference model of RAM and bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_dma_ci;

    logic        clock = 1'b0;
    logic        reset, start, granted, end_transaction_in, data_valid_in, busy_in, error_in;
    logic [31:0] valueA, valueB, address_data_in;
    logic [7:0]  ciN;
    logic        done, request, read_n_write_out, begin_transaction_out, end_transaction_out, data_valid_out;
    logic [31:0] result, address_data_out;
    logic [3:0]  byte_enables_out;
    logic [7:0]  burst_size_out;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] ref_ram [512];

    always #5 clock = ~clock;

    ram_dma_ci #(.customId(8'h00)) dut (
        .clock(clock), .reset(reset), .start(start), .valueA(valueA), .valueB(valueB),
        .ciN(ciN), .done(done), .result(result), .granted(granted),
        .address_data_in(address_data_in), .end_transaction_in(end_transaction_in),
        .data_valid_in(data_valid_in), .busy_in(busy_in), .error_in(error_in),
        .request(request), .address_data_out(address_data_out),
        .byte_enables_out(byte_enables_out), .burst_size_out(burst_size_out),
        .read_n_write_out(read_n_write_out), .begin_transaction_out(begin_transaction_out),
        .end_transaction_out(end_transaction_out), .data_valid_out(data_valid_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ci_write(input logic [2:0] s, input logic [8:0] a, input logic [31:0] d);
        @(negedge clock);
        start  = 1'b1;
        ciN    = 8'h00;
        valueA = {19'd0, s, 1'b1, a};
        valueB = d;
        #1;
        chk("ci_wr_done", 32'(done), 32'd1);
        chk("ci_wr_result", result, 32'd0);
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic ci_read(input logic [2:0] s, input logic [8:0] a, output logic [31:0] d);
        @(negedge clock);
        start  = 1'b1;
        ciN    = 8'h00;
        valueA = {19'd0, s, 1'b0, a};
        valueB = 32'd0;
        #1;
        d = result;
        chk("ci_rd_done", 32'(done), 32'd1);
        start = 1'b0;
    endtask

    // Programs a transfer, acts as bus slave until it completes, then checks
    // burst count, final status and (for reads) the RAM contents.
    task automatic run_xfer(input bit rd, input logic [31:0] baddr, input int rstart,
                            input int blk, input int bst, input bit poke);
        int remaining = blk;
        int exp_ram = rstart;
        int exp_bus = int'(baddr);
        int len = 0, beats = 0, nb = 0, cyc = 0, idle = 0, stall = 0;
        bit in_burst = 0, extra_now = 0, stall_done = 0;
        logic [31:0] d, st;
        ci_write(3'd1, 9'd0, baddr);
        ci_write(3'd2, 9'd0, 32'(rstart));
        ci_write(3'd3, 9'd0, 32'(blk));
        ci_write(3'd4, 9'd0, 32'(bst));
        ci_write(3'd5, 9'd0, rd ? 32'd1 : 32'd2);
        if (poke) begin
            ci_read(3'd5, 9'd0, st);
            chk("status_busy", st, 32'd1);
            ci_write(3'd5, 9'd0, 32'd1);   // must be ignored while busy
        end
        while (cyc < 4000 && idle < 4) begin
            @(negedge clock);
            cyc++;
            data_valid_in = 0; end_transaction_in = 0; busy_in = 0; address_data_in = 0;
            granted = request && ($urandom_range(0, 2) == 0);
            if (end_transaction_out) begin
                chk("wr_end_beats", (in_burst && !rd) ? 32'(beats) : 32'hFFFF_FFFF, 32'(len));
                in_burst = 0;
            end
            if (begin_transaction_out) begin
                len = (bst + 1 < remaining) ? bst + 1 : remaining;
                chk("beg_addr", address_data_out, 32'(exp_bus));
                chk("beg_bsize", 32'(burst_size_out), 32'(len - 1));
                chk("beg_rnw", 32'(read_n_write_out), 32'(rd));
                chk("beg_be", 32'(byte_enables_out), 32'hF);
                if (remaining == 0) chk("beg_unexpected", 32'd1, 32'd0);
                in_burst = 1; beats = 0; nb++;
                extra_now = rd && ($urandom_range(0, 2) == 0);
            end else if (in_burst && rd) begin
                if (beats < len) begin
                    if ($urandom_range(0, 3) != 0) begin
                        d = $urandom;
                        data_valid_in = 1; address_data_in = d;
                        ref_ram[exp_ram] = d;
                        exp_ram = (exp_ram + 1) % 512; exp_bus += 4; remaining--; beats++;
                        if (beats == len && !extra_now) begin
                            end_transaction_in = 1; in_burst = 0;
                        end
                    end
                end else begin
                    data_valid_in = 1; address_data_in = $urandom;
                    end_transaction_in = 1; in_burst = 0;
                end
            end else if (in_burst && !rd && data_valid_out) begin
                if (beats >= len) chk("wr_overrun", 32'(beats), 32'(len - 1));
                if (stall > 0) begin
                    busy_in = 1; stall--;
                end else if (nb == 2 && beats == 1 && !stall_done) begin
                    busy_in = 1; stall = 1; stall_done = 1;
                end else begin
                    busy_in = ($urandom_range(0, 4) == 0);
                end
                if (!busy_in) begin
                    chk("wr_data", address_data_out, ref_ram[exp_ram]);
                    exp_ram = (exp_ram + 1) % 512; exp_bus += 4; remaining--; beats++;
                end
            end
            if (remaining == 0 && !in_burst && !request && !begin_transaction_out) idle++;
            else idle = 0;
        end
        granted = 0; data_valid_in = 0; end_transaction_in = 0; busy_in = 0;
        chk("xfer_timeout", 32'(cyc < 4000), 32'd1);
        chk("nbursts", 32'(nb), 32'((blk + bst) / (bst + 1)));
        ci_read(3'd5, 9'd0, st);
        chk("status_after", st, 32'd0);
        ci_read(3'd1, 9'd0, st); chk("cfg_bus_kept", st, baddr);
        ci_read(3'd2, 9'd0, st); chk("cfg_ram_kept", st, 32'(rstart));
        if (rd) begin
            for (int i = 0; i < blk; i++) begin
                ci_read(3'd0, 9'((rstart + i) % 512), st);
                chk("rd_ram", st, ref_ram[(rstart + i) % 512]);
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [8:0]  addrs [16];
        int          cyc;
        reset = 1; start = 0; valueA = 0; valueB = 0; ciN = 0; granted = 0;
        address_data_in = 0; end_transaction_in = 0; data_valid_in = 0; busy_in = 0; error_in = 0;
        repeat (3) @(negedge clock);
        reset = 0;
        #1;
        chk("rst_request", 32'(request), 32'd0);
        chk("rst_begin", 32'(begin_transaction_out), 32'd0);
        chk("rst_addr_out", address_data_out, 32'd0);
        for (int s = 1; s <= 5; s++) begin
            ci_read(3'(s), 9'd0, d);
            chk("rst_reg", d, 32'd0);
        end

        // CI decode: wrong opcode or no strobe gives no response
        ci_write(3'd1, 9'd0, 32'hDEAD_BEEF);
        @(negedge clock);
        start = 1; ciN = 8'd7; valueA = 32'h400; #1;
        chk("ci_wrong_op_done", 32'(done), 32'd0);
        chk("ci_wrong_op_result", result, 32'd0);
        start = 0; ciN = 8'h00; #1;
        chk("ci_nostart_done", 32'(done), 32'd0);
        chk("ci_nostart_result", result, 32'd0);

        ci_write(3'd0, 9'h37, 32'h57);
        ci_read(3'd0, 9'h37, d);
        chk("ram_0x37", d, 32'h57);
        ref_ram[9'h37] = 32'h57;

        for (int s = 1; s <= 4; s++) begin
            logic [31:0] v;
            v = $urandom;
            ci_write(3'(s), 9'd0, v);
            ci_read(3'(s), 9'd0, d);
            case (s)
                1: chk("reg_bus_addr", d, v);
                2: chk("reg_ram_addr", d, v & 32'h1FF);
                3: chk("reg_block", d, v & 32'h3FF);
                default: chk("reg_burst", d, v & 32'hFF);
            endcase
        end

        for (int i = 0; i < 16; i++) begin
            addrs[i] = 9'($urandom_range(0, 511));
            d = $urandom;
            ci_write(3'd0, addrs[i], d);
            ref_ram[addrs[i]] = d;
        end
        for (int i = 0; i < 16; i++) begin
            ci_read(3'd0, addrs[i], d);
            chk("ram_rand", d, ref_ram[addrs[i]]);
        end

        // Bus read into 0x40..0x5F
        run_xfer(1'b1, 32'h17, 32'h40, 32, 7, 1'b0);

        // Bus write of a pre-filled region that wraps the RAM end
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            ci_write(3'd0, 9'((32'h1FA + i) % 512), d);
            ref_ram[(32'h1FA + i) % 512] = d;
        end
        run_xfer(1'b0, {$urandom_range(0, 32'hFFFF), 2'b00}, 32'h1FA, 16, 3, 1'b1);

        // Short final burst and wrapped read
        run_xfer(1'b1, {$urandom_range(0, 32'hFFFF), 2'b00}, 32'h1FC, 10, 3, 1'b0);

        // Error mid-burst
        ci_write(3'd1, 9'd0, 32'h1000);
        ci_write(3'd2, 9'd0, 32'h100);
        ci_write(3'd3, 9'd0, 32'd32);
        ci_write(3'd4, 9'd0, 32'd7);
        ci_write(3'd5, 9'd0, 32'd1);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clock);
            cyc++;
            granted = request;
            if (begin_transaction_out) break;
        end
        chk("err_begin_seen", 32'(cyc < 200), 32'd1);
        granted = 0;
        @(negedge clock);
        data_valid_in = 1; address_data_in = 32'hA5A5_0001;
        @(negedge clock);
        data_valid_in = 0; error_in = 1;
        chk("err_req_before", 32'(request), 32'd1);
        @(negedge clock);
        error_in = 0;
        chk("err_request", 32'(request), 32'd0);
        chk("err_begin", 32'(begin_transaction_out), 32'd0);
        chk("err_dv_out", 32'(data_valid_out), 32'd0);
        chk("err_be", 32'(byte_enables_out), 32'd0);
        ci_read(3'd0, 9'h100, d);
        chk("err_first_beat", d, 32'hA5A5_0001);
        ci_read(3'd5, 9'd0, d);
        chk("err_status", d, 32'd2);

        // Control code 3 is ignored: no request, error still set
        ci_write(3'd5, 9'd0, 32'd3);
        d = 0;
        repeat (6) begin
            @(negedge clock);
            d = d | 32'(request);
        end
        chk("ctrl3_no_request", d, 32'd0);
        ci_read(3'd5, 9'd0, d);
        chk("ctrl3_status", d, 32'd2);

        // Zero-length block completes at once and clears the error
        ci_write(3'd3, 9'd0, 32'd0);
        ci_write(3'd5, 9'd0, 32'd1);
        d = 0;
        repeat (6) begin
            @(negedge clock);
            d = d | 32'(request);
        end
        chk("blk0_no_request", d, 32'd0);
        ci_read(3'd5, 9'd0, d);
        chk("blk0_status", d, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
